// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, mul/div sequencing.
// Optional HAZ_PERF_EN adds a 32-bit stall cycle counter output.
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       use_rs,
   input  logic       use_rt,
   input  logic       d_muldiv,
   input  logic       d_isdiv,
   input  logic       d_mfhilo,
   input  logic       ewreg,
   input  logic [1:0] em2reg,
   input  logic [4:0] ern,
   input  logic       mwreg,
   input  logic [1:0] mm2reg,
   input  logic [4:0] mrn,
   output logic [1:0] fwda,
   output logic [1:0] fwdb,
   output logic       wpcir,
   output logic       bubble,
   output logic       md_start,
   output logic       md_div,
   output logic       md_busy,
`ifdef HAZ_PERF_EN
   output logic       hilo_we,
   output logic [31:0] stall_cnt
`else
   output logic       hilo_we
`endif
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   localparam logic [CNT_W-1:0] MUL_INI = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_INI = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_start_q, md_start_d;
   logic             md_div_q, md_div_d;
   logic             lu, ms, stall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] r);
      logic [1:0] sel;
      sel = 2'b00;
      if (ewreg && ern != 5'd0 && ern == r && em2reg != 2'b01)
         sel = 2'b01;
      else if (mwreg && mrn != 5'd0 && mrn == r)
         sel = (mm2reg == 2'b01) ? 2'b11 : 2'b10;
      return sel;
   endfunction

   always_comb begin
      fwda = fwd_sel(rs);
      fwdb = fwd_sel(rt);
   end

   always_comb begin
      lu = ewreg && em2reg == 2'b01 && ern != 5'd0 &&
           ((use_rs && ern == rs) || (use_rt && ern == rt));
      ms     = md_busy && (d_muldiv || d_mfhilo);
      stall  = lu || ms;
      wpcir  = ~stall;
      bubble = stall;
   end

   assign md_busy  = (state_q == S_BUSY);
   assign hilo_we  = md_busy && cnt_q == '0;
   assign md_start = md_start_q;
   assign md_div   = md_div_q;

   // A mul/div held back by a load-use stall is retried on a later cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      md_start_d = 1'b0;
      md_div_d   = md_div_q;
      case (state_q)
         S_IDLE: begin
            if (d_muldiv && !lu) begin
               state_d    = S_BUSY;
               cnt_d      = d_isdiv ? DIV_INI : MUL_INI;
               md_start_d = 1'b1;
               md_div_d   = d_isdiv;
            end
         end
         S_BUSY: begin
            if (cnt_q != '0)
               cnt_d = cnt_q - ONE;
            else
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         md_start_q <= 1'b0;
         md_div_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         md_start_q <= md_start_d;
         md_div_q   <= md_div_d;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!clrn)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected output vectors queued
// at drive time, popped and compared one time unit after each negedge.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic [4:0] rs, rt, ern, mrn;
   logic       use_rs, use_rt, d_muldiv, d_isdiv, d_mfhilo;
   logic       ewreg, mwreg;
   logic [1:0] em2reg, mm2reg;
   logic [1:0] fwda, fwdb;
   logic       wpcir, bubble, md_start, md_div, md_busy, hilo_we;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt;
`endif

   pipe_hazard_ctrl dut (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt),
      .use_rs(use_rs), .use_rt(use_rt),
      .d_muldiv(d_muldiv), .d_isdiv(d_isdiv), .d_mfhilo(d_mfhilo),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
      .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
      .md_start(md_start), .md_div(md_div), .md_busy(md_busy),
`ifdef HAZ_PERF_EN
      .hilo_we(hilo_we), .stall_cnt(stall_cnt)
`else
      .hilo_we(hilo_we)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [9:0] exp;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] mk(input logic [1:0] fa,
      input logic [1:0] fb, input logic wp, input logic bub,
      input logic st, input logic dv, input logic bz, input logic we);
      return {fa, fb, wp, bub, st, dv, bz, we};
   endfunction

   // obs layout: fwda, fwdb, wpcir, bubble, md_start, md_div, md_busy, hilo_we
   always @(negedge clk) begin
      #1;
      if (sb.size() > 0) begin
         sb_t e;
         e = sb.pop_front();
         chk(e.tag, {22'd0, fwda, fwdb, wpcir, bubble,
                     md_start, md_div, md_busy, hilo_we},
             {22'd0, e.exp});
      end
   end

   task automatic push(input string tag, input logic [9:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic clr_in();
      rs = 0; rt = 0; use_rs = 0; use_rt = 0;
      d_muldiv = 0; d_isdiv = 0; d_mfhilo = 0;
      ewreg = 0; em2reg = 0; ern = 0;
      mwreg = 0; mm2reg = 0; mrn = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clrn = 1'b0;
      clr_in();
      nxt();
      nxt();
      push("reset", mk(0, 0, 1, 0, 0, 0, 0, 0));

      // forwarding
      nxt(); clrn = 1'b1;
      ewreg = 1; ern = 5; mwreg = 1; mrn = 5; rs = 5;
      push("fwd_ex_prio", mk(1, 0, 1, 0, 0, 0, 0, 0));
      nxt(); ern = 0;
      push("fwd_mem_alu", mk(2, 0, 1, 0, 0, 0, 0, 0));
      nxt(); ern = 5; em2reg = 2;
      push("fwd_ex_hilo", mk(1, 0, 1, 0, 0, 0, 0, 0));
      nxt(); clr_in(); mwreg = 1; mm2reg = 1; mrn = 7; rt = 7;
      push("fwd_mem_ld", mk(0, 3, 1, 0, 0, 0, 0, 0));
      nxt(); mrn = 0;
      push("fwd_r0", mk(0, 0, 1, 0, 0, 0, 0, 0));
      nxt(); clr_in(); ewreg = 1; em2reg = 1; ern = 9; rs = 9; rt = 9;
      push("ld_nouse", mk(0, 0, 1, 0, 0, 0, 0, 0));
      nxt(); clr_in(); ewreg = 1; ern = 5; rs = 5; rt = 5;
      push("fwd_both", mk(1, 1, 1, 0, 0, 0, 0, 0));

      // load-use: three stalls
      nxt(); clr_in(); ewreg = 1; em2reg = 1; ern = 3; rs = 3; use_rs = 1;
      push("lu_rs", mk(0, 0, 0, 1, 0, 0, 0, 0));
      nxt(); use_rs = 0;
      push("lu_off", mk(0, 0, 1, 0, 0, 0, 0, 0));
      nxt(); rs = 0; rt = 3; use_rt = 1;
      push("lu_rt", mk(0, 0, 0, 1, 0, 0, 0, 0));
      nxt(); clr_in(); ewreg = 1; em2reg = 1; use_rs = 1;
      push("lu_r0", mk(0, 0, 1, 0, 0, 0, 0, 0));
      nxt(); ern = 8; rs = 8; mwreg = 1; mm2reg = 1; mrn = 8;
      push("lu_memld", mk(3, 0, 0, 1, 0, 0, 0, 0));

      // mult with mfhi held behind it
      nxt(); clr_in(); d_muldiv = 1;
      push("mul_acc", mk(0, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         nxt(); clr_in(); d_mfhilo = 1;
         push($sformatf("mfhi_wait%0d", k),
              mk(0, 0, 0, 1, k == 0, 0, 1, k == 3));
      end
      nxt(); d_mfhilo = 1;
      push("mfhi_go", mk(0, 0, 1, 0, 0, 0, 0, 0));
`ifdef HAZ_PERF_EN
      #1 chk("stall_cnt", stall_cnt, 32'd7);
`endif

      // div with mflo held, one cycle also load-use
      nxt(); clr_in(); d_muldiv = 1; d_isdiv = 1;
      push("div_acc", mk(0, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 32; k++) begin
         nxt(); clr_in(); d_mfhilo = 1;
         if (k == 10) begin
            ewreg = 1; em2reg = 1; ern = 3; rs = 3; use_rs = 1;
         end
         push($sformatf("div_wait%0d", k),
              mk(0, 0, 0, 1, k == 0, 1, 1, k == 31));
      end
      nxt(); clr_in(); d_mfhilo = 1;
      push("mflo_go", mk(0, 0, 1, 0, 0, 1, 0, 0));

      // back-to-back mult
      nxt(); clr_in(); d_muldiv = 1;
      push("mul1_acc", mk(0, 0, 1, 0, 0, 1, 0, 0));
      for (int k = 0; k < 4; k++) begin
         nxt(); d_muldiv = 1;
         push($sformatf("mul2_wait%0d", k),
              mk(0, 0, 0, 1, k == 0, 0, 1, k == 3));
      end
      nxt(); d_muldiv = 1;
      push("mul2_acc", mk(0, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 5; k < 9; k++) begin
         nxt(); clr_in();
         push($sformatf("mul2_run%0d", k),
              mk(0, 0, 1, 0, k == 5, 0, 1, k == 8));
      end
      nxt();
      push("mul2_done", mk(0, 0, 1, 0, 0, 0, 0, 0));

      // div blocked by load-use, then accepted
      nxt(); ewreg = 1; em2reg = 1; ern = 4; rs = 4; use_rs = 1;
      d_muldiv = 1; d_isdiv = 1;
      push("div_lu_blk", mk(0, 0, 0, 1, 0, 0, 0, 0));
      nxt(); clr_in(); d_muldiv = 1; d_isdiv = 1;
      push("div_lu_acc", mk(0, 0, 1, 0, 0, 0, 0, 0));
      nxt(); clr_in();
      push("div_lu_start", mk(0, 0, 1, 0, 1, 1, 1, 0));
      for (int k = 0; k < 2; k++) begin
         nxt();
         push($sformatf("div_run%0d", k), mk(0, 0, 1, 0, 0, 1, 1, 0));
      end

      // reset mid-div, then a fresh mult
      nxt(); clrn = 1'b0;
      push("rst_mid", mk(0, 0, 1, 0, 0, 1, 1, 0));
      nxt(); clrn = 1'b1; d_muldiv = 1;
      push("rst_mul_acc", mk(0, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         nxt(); clr_in();
         push($sformatf("rst_mul%0d", k),
              mk(0, 0, 1, 0, k == 0, 0, k < 4, k == 3));
      end

      for (int i = 0; i < 5 && sb.size() > 0; i++) nxt();
      nxt();
      chk("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
